alu_share_arbiter: RTL and testbench

Shares one 8-bit ALU instance between NREQ requesters using round-robin arbitration. It accepts one operation at a time over a valid/ready request port and drives the ALU from registered operands. It captures the result and zero flag, then returns them on a valid/ready response port tagged with the requester index. It sits between the requesting control units and the single ALU datapath.

---
 rtl/alu_share_arbiter_pkg.sv | 28 ++
 rtl/alu_share_arbiter_alu.sv | 41 ++++
 rtl/alu_share_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
//
// Shared definitions for the ALU sharing arbiter:
//   - state_t : control FSM encoding (IDLE -> EXEC -> RESP -> IDLE)
//   - OP_*    : ALUSel opcodes understood by the shared ALU
//
// Opcodes 3'b010 and 3'b011 are aliases of OP_SUB inside the ALU.
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

endpackage : alu_share_arbiter_pkg

// File: rtl/alu_share_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_alu
//
// The shared 8-bit combinational ALU. Results wrap modulo 256; there is no
// carry output.
//
// Ports:
//   A      in   8  operand A
//   B      in   8  operand B
//   ALUSel in   3  operation select (see OP_* in the package)
//   Result out  8  operation result
//   ZFlag  out  1  high when Result == 0
// ---------------------------------------------------------------------------
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] ALUSel,
    output logic [7:0] Result,
    output logic       ZFlag
);

    always_comb begin
        // NOTE: default assignment first so every path drives Result; a
        // missing branch in combinational logic would otherwise infer a latch.
        Result = 8'h00;
        case (ALUSel)
            OP_ADD:                     Result = A + B;
            OP_SUB, 3'b010, 3'b011:     Result = A - B;
            OP_OR:                      Result = A | B;
            OP_NOR:                     Result = ~(A | B);
            OP_AND:                     Result = A & B;
            OP_XOR:                     Result = A ^ B;
            default:                    Result = 8'h00;
        endcase
    end

    assign ZFlag = (Result == 8'h00);

endmodule : alu_share_arbiter_alu

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares a single 8-bit ALU between NREQ requesters. One operation is
// accepted at a time (round-robin among requesters holding req_valid), its
// operands are registered and presented to the ALU for one cycle, and the
// captured result/zero flag are returned on a valid/ready response port
// tagged with the requester index.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   NREQ    per-requester request valid
//   req_ready  out  NREQ    per-requester accept (one-hot or zero, IDLE only)
//   req_a      in   8*NREQ  operand A, requester i at [8i+7:8i]
//   req_b      in   8*NREQ  operand B, same packing
//   req_sel    in   3*NREQ  ALU select, requester i at [3i+2:3i]
//   rsp_valid  out  1       response valid
//   rsp_ready  in   1       response consumer ready
//   rsp_id     out  IDW     index of the requester owning the response
//   rsp_result out  8       captured ALU result
//   rsp_zero   out  1       captured zero flag
//   busy       out  1       high whenever the FSM is not in IDLE
//
// Timing: accept at edge T, result captured at edge T+1, rsp_valid visible
// after T+1. With rsp_ready held high one operation completes every 3 cycles.
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    input  logic [3*NREQ-1:0]    req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_result,
    output logic                 rsp_zero,
    output logic                 busy
);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t           state;
    logic [IDW-1:0]   ptr;        // index of the most recently served requester
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [2:0]       op_sel;

    // -----------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after ptr+1, wrapping.
    // Returns ptr when nothing is valid; callers qualify with any_valid.
    // -----------------------------------------------------------------------
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && valid[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic             any_valid;
    logic [IDW-1:0]   grant;
    logic [7:0]       grant_a;
    logic [7:0]       grant_b;
    logic [2:0]       grant_sel;

    assign any_valid = |req_valid;
    assign grant     = rr_pick(req_valid, ptr);

    // Operand mux for the winning requester and the one-hot accept strobe.
    always_comb begin
        grant_a   = 8'h00;
        grant_b   = 8'h00;
        grant_sel = 3'b000;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                grant_a   = req_a[8*i +: 8];
                grant_b   = req_b[8*i +: 8];
                grant_sel = req_sel[3*i +: 3];
                req_ready[i] = (state == IDLE) && any_valid;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Shared ALU, driven only from the operand registers
    // -----------------------------------------------------------------------
    logic [7:0] alu_result;
    logic       alu_zero;

    alu_share_arbiter_alu u_alu (
        .A      (op_a),
        .B      (op_b),
        .ALUSel (op_sel),
        .Result (alu_result),
        .ZFlag  (alu_zero)
    );

    // -----------------------------------------------------------------------
    // Control FSM with registered response outputs
    // -----------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so all state
    // updates see pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);   // requester 0 wins first
            op_a       <= 8'h00;
            op_b       <= 8'h00;
            op_sel     <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= 8'h00;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= grant_a;
                        op_b   <= grant_b;
                        op_sel <= grant_sel;
                        rsp_id <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // Held here for as long as the consumer back-pressures.
                    if (rsp_ready) begin
                        ptr       <= rsp_id;
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    // Unreachable encodings recover without issuing a response.
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed sequence followed by randomized operations, all checked against a
// behavioural model: grant = first valid requester after the last served one
// (with wrap), result = arithmetic of the selected operation modulo 256.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [8*NREQ-1:0]    req_a;
    logic [8*NREQ-1:0]    req_b;
    logic [3*NREQ-1:0]    req_sel;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_result;
    logic                 rsp_zero;
    logic                 busy;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Requester-side stimulus state
    logic [NREQ-1:0] valid;
    logic [7:0]      a_arr   [NREQ];
    logic [7:0]      b_arr   [NREQ];
    logic [2:0]      sel_arr [NREQ];

    // Model state
    int last_served = NREQ - 1;
    int last_rsp_cycle = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel);
        int r;
        case (sel)
            3'd0:             r = int'(a) + int'(b);
            3'd1, 3'd2, 3'd3: r = int'(a) - int'(b) + 256;
            3'd4:             r = int'(a | b);
            3'd5:             r = 255 - int'(a | b);
            3'd6:             r = int'(a & b);
            default:          r = int'(a ^ b);
        endcase
        return 8'(r % 256);
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = valid;
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8]   = a_arr[i];
            req_b[8*i +: 8]   = b_arr[i];
            req_sel[3*i +: 3] = sel_arr[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] sel);
        valid[i]   = 1'b1;
        a_arr[i]   = a;
        b_arr[i]   = b;
        sel_arr[i] = sel;
    endtask

    // One full operation from IDLE back to IDLE. Called at a quiet phase
    // just after a rising edge with the FSM in IDLE.
    task automatic do_op(input string tag, input int stall, input bit drop,
                         input bit check_gap, output int g);
        logic [7:0] er;
        drive();
        #1;
        g = model_grant(valid, last_served);
        if (g < 0) begin
            check({tag, "/no_ready"}, 32'(req_ready), 32'h0);
            return;
        end
        er = alu_ref(a_arr[g], b_arr[g], sel_arr[g]);
        check({tag, "/req_ready"}, 32'(req_ready), 32'(1 << g));
        tick();                                   // accept edge
        if (drop) valid[g] = 1'b0;
        drive();
        rsp_ready = (stall == 0);
        #1;
        check({tag, "/exec_busy"}, 32'(busy), 32'h1);
        check({tag, "/exec_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "/exec_req_ready"}, 32'(req_ready), 32'h0);
        tick();                                   // result captured
        check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, "/rsp_id"}, 32'(rsp_id), 32'(g));
        check({tag, "/rsp_result"}, 32'(rsp_result), 32'(er));
        check({tag, "/rsp_zero"}, 32'(rsp_zero), 32'(er == 8'h00));
        if (check_gap) check({tag, "/rsp_gap"}, 32'(cycle - last_rsp_cycle), 32'd3);
        last_rsp_cycle = cycle;
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "/hold_valid"}, 32'(rsp_valid), 32'h1);
            check({tag, "/hold_id"}, 32'(rsp_id), 32'(g));
            check({tag, "/hold_result"}, 32'(rsp_result), 32'(er));
            check({tag, "/hold_req_ready"}, 32'(req_ready), 32'h0);
            check({tag, "/hold_busy"}, 32'(busy), 32'h1);
        end
        rsp_ready = 1'b1;
        tick();                                   // handshake edge
        last_served = g;
        check({tag, "/done_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "/done_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int g;
        int rr_order [5] = '{0, 1, 2, 3, 0};
        bit bad_fsm;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        valid     = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 8'h00; b_arr[i] = 8'h00; sel_arr[i] = 3'b000;
        end
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
        drive();
        repeat (3) tick();

        // ---- reset state -------------------------------------------------
        check("rst/rsp_valid",  32'(rsp_valid),  32'h0);
        check("rst/rsp_id",     32'(rsp_id),     32'h0);
        check("rst/rsp_result", 32'(rsp_result), 32'h0);
        check("rst/rsp_zero",   32'(rsp_zero),   32'h0);
        check("rst/busy",       32'(busy),       32'h0);
        rst_n = 1'b1;
        tick();
        check("idle/req_ready", 32'(req_ready), 32'h0);
        check("idle/busy",      32'(busy),      32'h0);

        // ---- single request ---------------------------------------------
        set_req(0, 8'h05, 8'h03, 3'b000);
        do_op("single_add", 0, 1'b1, 1'b0, g);
        check("single_add/value", 32'(rsp_result), 32'h08);

        // ---- zero and wrap-around ---------------------------------------
        set_req(2, 8'h10, 8'h10, 3'b010);
        do_op("sub_zero", 0, 1'b1, 1'b0, g);
        set_req(2, 8'hFF, 8'h01, 3'b000);
        do_op("add_wrap", 0, 1'b1, 1'b0, g);
        set_req(2, 8'h00, 8'h01, 3'b001);
        do_op("sub_wrap", 0, 1'b1, 1'b0, g);
        check("sub_wrap/value", 32'(rsp_result), 32'hFF);

        // ---- logic ops (requester 3, so the next round starts at 0) -----
        set_req(3, 8'hF0, 8'h3C, 3'b100);
        do_op("op_or", 0, 1'b1, 1'b0, g);
        check("op_or/value", 32'(rsp_result), 32'hFC);
        set_req(3, 8'hF0, 8'h3C, 3'b101);
        do_op("op_nor", 0, 1'b1, 1'b0, g);
        check("op_nor/value", 32'(rsp_result), 32'h03);
        set_req(3, 8'hF0, 8'h3C, 3'b110);
        do_op("op_and", 0, 1'b1, 1'b0, g);
        check("op_and/value", 32'(rsp_result), 32'h30);
        set_req(3, 8'hF0, 8'h3C, 3'b111);
        do_op("op_xor", 0, 1'b1, 1'b0, g);
        check("op_xor/value", 32'(rsp_result), 32'hCC);

        // ---- round-robin with all requesters holding valid --------------
        set_req(0, 8'h11, 8'h01, 3'b000);
        set_req(1, 8'h22, 8'h02, 3'b001);
        set_req(2, 8'h33, 8'h0F, 3'b110);
        set_req(3, 8'h44, 8'h04, 3'b111);
        for (int k = 0; k < 5; k++) begin
            do_op("rr", 0, 1'b0, k > 0, g);
            check("rr/order", 32'(g), 32'(rr_order[k]));
        end

        // ---- back-pressure: 5 stalled cycles in RESP ---------------------
        do_op("backpressure", 5, 1'b0, 1'b0, g);
        check("backpressure/id", 32'(g), 32'd1);
        valid = '0;
        drive();

        // ---- reset during EXEC -------------------------------------------
        set_req(2, 8'h07, 8'h09, 3'b000);
        drive();
        #1;
        check("midrst/req_ready", 32'(req_ready), 32'b0100);
        tick();                                   // accepted, now in EXEC
        valid = '0;
        drive();
        check("midrst/busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst/rsp_valid",  32'(rsp_valid),  32'h0);
        check("midrst/busy",       32'(busy),       32'h0);
        check("midrst/rsp_id",     32'(rsp_id),     32'h0);
        check("midrst/rsp_result", 32'(rsp_result), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        last_served = NREQ - 1;
        bad_fsm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad_fsm = 1'b1;
        end
        check("midrst/no_response", 32'(bad_fsm), 32'h0);
        set_req(1, 8'h20, 8'h05, 3'b001);
        do_op("after_rst", 0, 1'b1, 1'b0, g);
        check("after_rst/id", 32'(g), 32'd1);

        // ---- randomized traffic ------------------------------------------
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 8'($urandom), 8'($urandom), 3'($urandom));
                end
            end
            if (valid == '0) begin
                set_req(int'($urandom_range(0, NREQ - 1)), 8'($urandom),
                        8'($urandom), 3'($urandom));
            end
            do_op("random", int'($urandom_range(0, 2)), 1'b1, 1'b0, g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_alu_share_arbiter
